cmutex_merge_n_sync: RTL and testbench

CMUTEX_MERGE_N_SYNC -- requirements
Module: cmutex_merge_n_sync

---
 rtl/cmutex_merge_n_sync.sv | 170 +++++++++++++++++
 tb/tb_cmutex_merge_n_sync.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cmutex_merge_n_sync.sv
// cmutex_merge_n_sync: merges CH pulse-handshake token channels into a single
// downstream pulse-handshake stream through a DEPTH-entry queue. Each channel
// has a one-token holding register. An arbiter (fixed priority or round-robin)
// moves at most one held token per cycle into the queue. A two-state output
// FSM offers the queue head downstream.
module cmutex_merge_n_sync #(
  parameter int CH    = 4,
  parameter int DW    = 1,
  parameter int DEPTH = 4,
  parameter int MODE  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH-1:0]                i_drive,
  input  logic [CH*DW-1:0]             i_data,
  output logic [CH-1:0]                o_free,
  output logic                         o_driveNext,
  output logic [DW-1:0]                o_data,
  output logic [$clog2(CH)-1:0]        o_src,
  input  logic                         i_freeNext,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_ovf
);
  localparam int SW = $clog2(CH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic [CH-1:0]         pending_q, pending_d;
  logic [CH-1:0][DW-1:0] hold_q, hold_d;
  logic [CH-1:0]         drop;
  logic [SW-1:0]         rr_q, rr_d;
  logic [CH-1:0]         free_q, free_d;
  logic                  drv_q, drv_d;
  logic [DW-1:0]         data_q, data_d;
  logic [SW-1:0]         src_q, src_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  state_t                state_q, state_d;

  logic                  grant_vld;
  logic [SW-1:0]         grant_idx;
  logic [CH-1:0]         gnt_oh;
  logic                  push, pop;

  // Queue storage; each entry is {source channel, data}.
  logic [SW+DW-1:0]      mem [DEPTH];

  // Arbiter: pick one pending channel, only while the queue has room.
  always_comb begin
    logic [SW-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if (count_q < CW'(DEPTH)) begin
      if (MODE == 0) begin
        // Descending scan so the lowest pending index is the last one written.
        for (int i = CH - 1; i >= 0; i--) begin
          idx = SW'(i);
          if (pending_q[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
          end
        end
      end else begin
        // Offsets CH..1 from the last grant; the smallest offset wins.
        for (int k = CH; k >= 1; k--) begin
          idx = SW'((int'(rr_q) + k) % CH);
          if (pending_q[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
          end
        end
      end
    end
  end

  assign gnt_oh = grant_vld ? (CH'(1) << grant_idx) : '0;

  // Per-channel holding registers. A new token is accepted when the slot is
  // empty or is being emptied by a grant this cycle; otherwise it is dropped.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    logic take;
    assign take          = i_drive[gi] && (!pending_q[gi] || gnt_oh[gi]);
    assign drop[gi]      = i_drive[gi] && pending_q[gi] && !gnt_oh[gi];
    assign pending_d[gi] = take || (pending_q[gi] && !gnt_oh[gi]);
    assign hold_d[gi]    = take ? i_data[gi*DW +: DW] : hold_q[gi];
  end

  assign push = grant_vld;
  assign pop  = (state_q == ST_WAIT) && i_freeNext;

  // Queue pointers, occupancy, output FSM and the sticky overflow flag.
  always_comb begin
    free_d  = gnt_oh;
    rr_d    = grant_vld ? grant_idx : rr_q;
    ovf_d   = ovf_q | (|drop);
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q;
    state_d = state_q;
    drv_d   = 1'b0;
    data_d  = data_q;
    src_d   = src_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      ST_IDLE: begin
        // Head is loaded here and held unchanged for the whole WAIT.
        if (count_q != '0) begin
          state_d         = ST_WAIT;
          drv_d           = 1'b1;
          {src_d, data_d} = mem[rd_q];
        end
      end
      ST_WAIT: begin
        if (i_freeNext) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      hold_q    <= '0;
      rr_q      <= SW'(CH - 1);
      free_q    <= '0;
      drv_q     <= 1'b0;
      data_q    <= '0;
      src_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      state_q   <= ST_IDLE;
    end else begin
      pending_q <= pending_d;
      hold_q    <= hold_d;
      rr_q      <= rr_d;
      free_q    <= free_d;
      drv_q     <= drv_d;
      data_q    <= data_d;
      src_q     <= src_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      state_q   <= state_d;
    end
  end

  // Queue write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {grant_idx, hold_q[grant_idx]};
  end

  assign o_free      = free_q;
  assign o_driveNext = drv_q;
  assign o_data      = data_q;
  assign o_src       = src_q;
  assign o_count     = count_q;
  assign o_ovf       = ovf_q;
endmodule

// File: tb/tb_cmutex_merge_n_sync.sv
// Directed bench: dut_a is round-robin, dut_b is fixed priority; both CH=4,
// DW=4, DEPTH=4.
module tb_cmutex_merge_n_sync;
  logic        clk;
  int          checks = 0;
  int          errors = 0;

  logic        rst_a, dn_a, fn_a, ovf_a;
  logic [3:0]  drv_a, free_a, od_a;
  logic [15:0] data_a;
  logic [1:0]  src_a;
  logic [2:0]  cnt_a;

  logic        rst_b, dn_b, fn_b, ovf_b;
  logic [3:0]  drv_b, free_b, od_b;
  logic [15:0] data_b;
  logic [1:0]  src_b;
  logic [2:0]  cnt_b;

  cmutex_merge_n_sync #(.CH(4), .DW(4), .DEPTH(4), .MODE(1)) dut_a (
    .clk(clk), .rst(rst_a), .i_drive(drv_a), .i_data(data_a),
    .o_free(free_a), .o_driveNext(dn_a), .o_data(od_a), .o_src(src_a),
    .i_freeNext(fn_a), .o_count(cnt_a), .o_ovf(ovf_a));

  cmutex_merge_n_sync #(.CH(4), .DW(4), .DEPTH(4), .MODE(0)) dut_b (
    .clk(clk), .rst(rst_b), .i_drive(drv_b), .i_data(data_b),
    .o_free(free_b), .o_driveNext(dn_b), .o_data(od_b), .o_src(src_b),
    .i_freeNext(fn_b), .o_count(cnt_b), .o_ovf(ovf_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for an offer on dut_a, check it, consume it in that cycle.
  task automatic drain_a(input int s, input int d);
    int n;
    n = 0;
    while (!dn_a && n < 20) begin
      tick;
      n++;
    end
    chk("drain_offer", 32'(dn_a), 1);
    chk("drain_src", 32'(src_a), 32'(s));
    chk("drain_data", 32'(od_a), 32'(d));
    fn_a = 1'b1;
    tick;
    fn_a = 1'b0;
  endtask

  initial begin
    int n1;
    int seen3;
    drv_a = '0; data_a = '0; fn_a = 1'b0; rst_a = 1'b1;
    drv_b = '0; data_b = '0; fn_b = 1'b0; rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("rst_free", 32'(free_a), 0);
    chk("rst_dn", 32'(dn_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_data", 32'(od_a), 0);
    chk("rst_src", 32'(src_a), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick;

    // Single token: drive cycle 0, o_free cycle 2, offer cycle 3
    drv_a = 4'b0001; data_a[3:0] = 4'h1;
    tick;
    drv_a = '0;
    chk("t1_free_c1", 32'(free_a), 0);
    tick;
    chk("t1_free_c2", 32'(free_a), 32'h1);
    chk("t1_count_c2", 32'(cnt_a), 1);
    chk("t1_dn_c2", 32'(dn_a), 0);
    tick;
    chk("t1_dn_c3", 32'(dn_a), 1);
    chk("t1_data_c3", 32'(od_a), 1);
    chk("t1_src_c3", 32'(src_a), 0);
    fn_a = 1'b1;               // consume in the same cycle as the offer
    tick;
    fn_a = 1'b0;
    chk("t1_count_c4", 32'(cnt_a), 0);
    chk("t1_dn_c4", 32'(dn_a), 0);

    // Fresh reset so the RR pointer starts at CH-1
    rst_a = 1'b1; tick; rst_a = 1'b0; tick;

    // RR fairness, full queue, overflow, ignored i_freeNext in IDLE
    data_a = 16'h8765; drv_a = 4'hF;
    tick;                                   // c1
    drv_a = '0;
    tick;                                   // c2
    chk("rr_free_c2", 32'(free_a), 32'h1);
    tick;                                   // c3
    chk("rr_free_c3", 32'(free_a), 32'h2);
    chk("rr_dn_c3", 32'(dn_a), 1);
    chk("rr_src_c3", 32'(src_a), 0);
    chk("rr_data_c3", 32'(od_a), 5);
    tick;                                   // c4
    chk("rr_free_c4", 32'(free_a), 32'h4);
    chk("rr_count_c4", 32'(cnt_a), 3);
    drv_a = 4'b0100; data_a[11:8] = 4'hA;   // fifth token on channel 2
    tick;                                   // c5
    drv_a = '0;
    chk("rr_free_c5", 32'(free_a), 32'h8);
    chk("full_count_c5", 32'(cnt_a), 4);
    tick;                                   // c6
    chk("full_free_c6", 32'(free_a), 0);
    chk("full_count_c6", 32'(cnt_a), 4);
    chk("ovf_pre", 32'(ovf_a), 0);
    drv_a = 4'b0100; data_a[11:8] = 4'hB;   // ch2 still pending, queue full
    tick;                                   // c7
    drv_a = '0;
    chk("ovf_set", 32'(ovf_a), 1);
    chk("full_free_c7", 32'(free_a), 0);
    tick;                                   // c8: first pop
    fn_a = 1'b1;
    tick;                                   // c9: IDLE, fn held high is ignored
    chk("pop_count_c9", 32'(cnt_a), 3);
    chk("pop_free_c9", 32'(free_a), 0);
    tick;                                   // c10
    fn_a = 1'b0;
    chk("fifth_free_c10", 32'(free_a), 32'h4);
    chk("idle_ignore_count", 32'(cnt_a), 4);
    drain_a(1, 6);
    drain_a(2, 7);
    drain_a(3, 8);
    drain_a(2, 10);                         // the first token on ch2, not 0xB
    chk("drained_count", 32'(cnt_a), 0);
    chk("ovf_sticky", 32'(ovf_a), 1);

    // Reset mid-flight with three tokens queued; last grant was ch2
    data_a = 16'h0321; drv_a = 4'b0111;
    tick;                                   // c1
    drv_a = '0;
    tick;                                   // c2
    chk("mid_free_c2", 32'(free_a), 32'h1);
    tick; tick; tick;                       // c5
    chk("mid_count_c5", 32'(cnt_a), 3);
    drv_a = 4'b1000; rst_a = 1'b1;
    #1;
    chk("mid_rst_count", 32'(cnt_a), 0);
    chk("mid_rst_dn", 32'(dn_a), 0);
    chk("mid_rst_free", 32'(free_a), 0);
    chk("mid_rst_ovf", 32'(ovf_a), 0);
    tick;
    drv_a = '0; rst_a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("post_rst_free", 32'(free_a), 0);
      chk("post_rst_dn", 32'(dn_a), 0);
    end
    chk("post_rst_count", 32'(cnt_a), 0);

    // Fixed priority: fill the queue from ch0 (driving during grants keeps
    // the channel pending), then ch1 and ch3 contend for each freed slot.
    for (int c = 0; c < 4; c++) begin
      drv_b = 4'b0001; data_b[3:0] = 4'(c + 1);
      tick;
    end
    drv_b = '0;
    tick;                                   // c5
    chk("fp_fill_count", 32'(cnt_b), 4);
    drv_b = 4'b1010; data_b[7:4] = 4'h5; data_b[15:12] = 4'h9;
    tick;                                   // c6
    drv_b = '0; fn_b = 1'b1;                // B has sat in WAIT since c3
    tick;
    fn_b = 1'b0;
    n1 = 0;
    for (int c = 0; c < 40; c++) begin
      drv_b = '0; fn_b = 1'b0;
      chk("fp_starve3", 32'(free_b[3]), 0);
      if (free_b[1]) begin
        n1++;
        drv_b = 4'b0010;
      end
      if (dn_b) fn_b = 1'b1;
      tick;
    end
    chk("fp_ch1_wins", 32'(n1 >= 10), 1);
    seen3 = 0;
    for (int c = 0; c < 20; c++) begin
      drv_b = '0; fn_b = 1'b0;
      if (free_b[3]) seen3++;
      if (dn_b) fn_b = 1'b1;
      tick;
    end
    drv_b = '0; fn_b = 1'b0;
    chk("fp_ch3_after", 32'(seen3), 1);
    chk("fp_ovf", 32'(ovf_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
